// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bfloat16 class encoding, field positions and queue entry.
package bf16_pkg;

    typedef enum logic [2:0] {
        BF16_ZERO,
        BF16_SUBNORMAL,
        BF16_NORMAL,
        BF16_INF,
        BF16_NAN
    } bf16_class_t;

    localparam logic [7:0] BF16_EXP_MAX = 8'd255;
    localparam int BF16_EXP_LSB = 7;
    localparam int BF16_EXP_MSB = 14;
    localparam int BF16_SIGN = 15;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        bf16_class_t class_a;
        bf16_class_t class_b;
    } bf16_entry_t;

endpackage

// File: rtl/bf16_classify.sv
// bf16_classify: combinational bfloat16 operand classifier.
// Define BF16_DAZ_EN to flush subnormals to signed zero.
module bf16_classify
    import bf16_pkg::*;
(
    input  logic [15:0] operand,
    output logic [15:0] adjusted,
    output bf16_class_t op_class
);

    logic [7:0] exp_f;
    logic [6:0] man_f;

    assign exp_f = operand[BF16_EXP_MSB:BF16_EXP_LSB];
    assign man_f = operand[BF16_EXP_LSB-1:0];

    always_comb begin
        adjusted = operand;
        op_class = BF16_NORMAL;
        unique case (1'b1)
            (exp_f == 8'd0) && (man_f == 7'd0): op_class = BF16_ZERO;
            (exp_f == 8'd0) && (man_f != 7'd0): begin
`ifdef BF16_DAZ_EN
                adjusted = {operand[BF16_SIGN], 15'b0};
                op_class = BF16_ZERO;
`else
                op_class = BF16_SUBNORMAL;
`endif
            end
            (exp_f == BF16_EXP_MAX) && (man_f == 7'd0): op_class = BF16_INF;
            (exp_f == BF16_EXP_MAX) && (man_f != 7'd0): op_class = BF16_NAN;
            default: op_class = BF16_NORMAL;
        endcase
    end

endmodule

// File: rtl/bf16_operand_queue.sv
// bf16_operand_queue: classified operand-pair FIFO feeding bfloat16_adder.
// Define BF16_DAZ_EN to flush subnormal operands to signed zero on push.
module bf16_operand_queue
    import bf16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             adder_ready,
    output logic [15:0]      a,
    output logic [15:0]      b,
    output logic             out_valid,
    output bf16_class_t      class_a,
    output bf16_class_t      class_b,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic [15:0]      issued
);

    localparam int PTR_W = $clog2(DEPTH);

    bf16_entry_t      mem [DEPTH];
    bf16_entry_t      wr_entry;
    bf16_entry_t      head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [15:0]      adj_a;
    logic [15:0]      adj_b;
    bf16_class_t      cls_a;
    bf16_class_t      cls_b;
    logic             push;
    logic             pop;

    bf16_classify u_cls_a (
        .operand  (in_a),
        .adjusted (adj_a),
        .op_class (cls_a)
    );

    bf16_classify u_cls_b (
        .operand  (in_b),
        .adjusted (adj_b),
        .op_class (cls_b)
    );

    assign wr_entry = '{a: adj_a, b: adj_b, class_a: cls_a, class_b: cls_b};
    assign head     = mem[rd_ptr];

    // Flags come from the registered count only, so in_ready never sees adder_ready.
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = adder_ready & ~empty;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            a         <= 16'h0000;
            b         <= 16'h0000;
            out_valid <= 1'b0;
            class_a   <= BF16_ZERO;
            class_b   <= BF16_ZERO;
            issued    <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                issued <= issued + 16'd1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // An empty queue still answers the adder, with a 0+0 filler pair.
            if (adder_ready) begin
                if (!empty) begin
                    a         <= head.a;
                    b         <= head.b;
                    class_a   <= head.class_a;
                    class_b   <= head.class_b;
                    out_valid <= 1'b1;
                end else begin
                    a         <= 16'h0000;
                    b         <= 16'h0000;
                    class_a   <= BF16_ZERO;
                    class_b   <= BF16_ZERO;
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/bf16_operand_queue.md
Name: bf16_operand_queue

Overview:
- Upstream feeder for bfloat16_adder.
- Buffers (a, b) operand pairs from the producer under a valid/ready handshake, classifies each operand on entry, and presents one pair to the adder per adder ready pulse.
- Holds a/b stable across the adder's two read states, so the adder needs no input registers of its own.

Parameters:
DEPTH, 4, number of operand-pair entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a pair on in_a/in_b
in_ready  output  1  queue accepts a pair this cycle
in_a  input  16  bfloat16 operand A
in_b  input  16  bfloat16 operand B
adder_ready  input  1  adder's ready output (one-cycle pulse in adder_ready state)
a  output  16  registered operand A to adder
b  output  16  registered operand B to adder
out_valid  output  1  a/b hold a real queued pair, not filler
class_a  output  3  bf16_class_t of a
class_b  output  3  bf16_class_t of b
count  output  CNT_W  entries currently queued
empty  output  1  count == 0
full  output  1  count == DEPTH
issued  output  16  pairs issued since reset; wraps 16'hFFFF -> 0

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: pointers 0, count 0, a = b = 16'h0000, out_valid 0, class_a = class_b = BF16_ZERO, issued 0.
  - Reset mid-operation discards all entries; a pair pushed in the reset cycle is lost.
- Storage: circular buffer of DEPTH entries. Each entry holds {in_a, in_b, class(in_a), class(in_b)}.
  - Classification happens on push.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
- Push:
  - in_ready = ~full, from registered count only; no combinational path from adder_ready.
  - push = in_valid & in_ready. Entry is written at the clock edge and is visible at the head the next cycle.
- Issue, on an edge where adder_ready == 1:
  - If not empty: load head into a/b/class_a/class_b, set out_valid = 1, pop, and increment issued.
  - If empty: load a = b = 16'h0000 and class = BF16_ZERO, set out_valid = 0, do not pop, and leave issued unchanged. The adder then computes a harmless 0+0.
- Outputs a/b/class/out_valid change only on adder_ready edges or reset. They are otherwise held, which covers the adder's reading_first_input and reading_second_input states.
- Latency:
  - Push at edge N, with the queue empty, can issue at the first adder_ready edge >= N+1.
  - No same-cycle bypass: a push and an adder_ready in the same cycle with the queue empty issue filler.
- Simultaneous push and pop: count is unchanged. While full, no push is accepted that cycle (strict in_ready = ~full).
- Count is always updated as count + push - pop, never exceeding DEPTH.
- Classification, by exponent e and mantissa m:
  - e == 0, m == 0: ZERO
  - e == 0, m != 0: SUBNORMAL
  - e == 255, m == 0: INF
  - e == 255, m != 0: NAN
  - otherwise: NORMAL
  - Sign is ignored.

Optional Feature:
BF16_DAZ_EN
- Defined: on push, any SUBNORMAL operand is replaced by a signed zero {sign, 15'b0} and classified ZERO. Class SUBNORMAL never appears at the outputs.
- Undefined: operands are stored bit-exact and SUBNORMAL is reported as-is.

Decomposition:
- Package bf16_pkg:
  - typedef enum logic [2:0] bf16_class_t {BF16_ZERO, BF16_SUBNORMAL, BF16_NORMAL, BF16_INF, BF16_NAN}
  - localparams BF16_EXP_MAX = 8'd255, BF16_EXP_LSB = 7, BF16_EXP_MSB = 14, BF16_SIGN = 15
  - packed struct bf16_entry_t
- Sub-module bf16_classify: purely combinational, 16-bit in -> bf16_class_t plus DAZ-adjusted value. Instantiated twice, on in_a and in_b.

Test Plan:
- Reset, then pulse adder_ready with queue empty -> a = b = 16'h0000, out_valid = 0, issued = 0, empty = 1.
- Push (3F80, 4000), then adder_ready pulse -> a = 3F80, b = 4000, class NORMAL/NORMAL, out_valid = 1, issued = 1; a/b stable for the following 2 cycles.
- Push DEPTH pairs with no adder_ready -> full = 1, in_ready = 0, count = DEPTH; a 5th in_valid is ignored. One adder_ready plus push in the same cycle -> count stays 4 if in_ready was low, else unchanged net; FIFO order preserved across pointer wrap.
- Push (7F80, 7FC1), (0000, 8001) -> classes INF/NAN, then ZERO/SUBNORMAL. With BF16_DAZ_EN, b = 8000 and class ZERO.
- Assert reset with 3 entries queued and a/b loaded -> next cycle count = 0, out_valid = 0, a = 0; a subsequent adder_ready issues filler.
- Push 1 pair each cycle while adder_ready pulses every 3rd cycle for 70000 issues -> issued wraps to 0 after FFFF; no pair lost or duplicated (scoreboard).
